// File: rtl/i2c_pkg.sv
// Shared types and constants for the WM8731-style I2C control target.
// Optional shadow register file is enabled by defining I2C_TARGET_SHADOW_EN.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DEV       = 3'd1,
    ACK_DEV   = 3'd2,
    B1        = 3'd3,
    ACK1      = 3'd4,
    B2        = 3'd5,
    ACK2      = 3'd6,
    WAIT_STOP = 3'd7
  } i2c_state_e;

  localparam logic [6:0] I2C_DEV_ADDR_DEFAULT = 7'h1A;
  localparam int unsigned SHADOW_DEPTH = 16;

  // Codec control register map
  localparam logic [6:0] I2C_REG_LLINVOL = 7'h00;
  localparam logic [6:0] I2C_REG_RLINVOL = 7'h01;
  localparam logic [6:0] I2C_REG_LHPOUT  = 7'h02;
  localparam logic [6:0] I2C_REG_RHPOUT  = 7'h03;
  localparam logic [6:0] I2C_REG_APANA   = 7'h04;
  localparam logic [6:0] I2C_REG_DPATH   = 7'h05;
  localparam logic [6:0] I2C_REG_PWR     = 7'h06;
  localparam logic [6:0] I2C_REG_DAIF    = 7'h07;
  localparam logic [6:0] I2C_REG_SRATE   = 7'h08;
  localparam logic [6:0] I2C_REG_ACTIVE  = 7'h09;
  localparam logic [6:0] I2C_REG_RESET   = 7'h0F;

  function automatic logic is_shadow_addr(input logic [6:0] addr);
    return (addr < 7'd16);
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizers for SCL/SDA plus edge, START and STOP detection
// on the synchronized lines.
module i2c_line_sync
  import i2c_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  logic scl_meta_q, scl_meta_d;
  logic scl_sync_q, scl_sync_d;
  logic scl_prev_q, scl_prev_d;
  logic sda_meta_q, sda_meta_d;
  logic sda_sync_q, sda_sync_d;
  logic sda_prev_q, sda_prev_d;

  // Next-state for synchronizer and history stages
  always_comb begin
    scl_meta_d = i_scl;
    scl_sync_d = scl_meta_q;
    scl_prev_d = scl_sync_q;
    sda_meta_d = i_sda;
    sda_sync_d = sda_meta_q;
    sda_prev_d = sda_sync_q;
  end

  // Idle bus is high, so the stages reset to 1 to avoid a false edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_meta_q <= scl_meta_d;
      scl_sync_q <= scl_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_meta_q <= sda_meta_d;
      sda_sync_q <= sda_sync_d;
      sda_prev_q <= sda_prev_d;
    end
  end

  assign o_sda      = sda_sync_q;
  assign o_scl_rise = scl_sync_q & ~scl_prev_q;
  assign o_scl_fall = ~scl_sync_q & scl_prev_q;
  // SCL must be high on both samples so a data change near an SCL edge is not mistaken
  assign o_start    = scl_sync_q & scl_prev_q & sda_prev_q & ~sda_sync_q;
  assign o_stop     = scl_sync_q & scl_prev_q & ~sda_prev_q & sda_sync_q;

endmodule

// File: rtl/i2c_codec_target.sv
// Write-only I2C target for codec control: device byte, then a 7-bit register
// address and 9-bit data. Shadow registers exist only with I2C_TARGET_SHADOW_EN.
module i2c_codec_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = I2C_DEV_ADDR_DEFAULT
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_oe,
  output logic       o_reg_we,
  output logic [6:0] o_reg_addr,
  output logic [8:0] o_reg_data,
  output logic       o_busy,
  output logic       o_err,
  input  logic [3:0] i_rd_addr,
  output logic [8:0] o_rd_data
);

  logic sda_s, scl_rise_s, scl_fall_s, start_s, stop_s;

  i2c_line_sync u_line_sync (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_scl      (i_scl),
    .i_sda      (i_sda),
    .o_sda      (sda_s),
    .o_scl_rise (scl_rise_s),
    .o_scl_fall (scl_fall_s),
    .o_start    (start_s),
    .o_stop     (stop_s)
  );

  i2c_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] b1_q, b1_d;
  logic       byte_done_q, byte_done_d;
  logic       post_ack2_q, post_ack2_d;
  logic       sda_oe_q, sda_oe_d;
  logic       reg_we_q, reg_we_d;
  logic [6:0] reg_addr_q, reg_addr_d;
  logic [8:0] reg_data_q, reg_data_d;
  logic       busy_q, busy_d;
  logic       err_q, err_d;

  // Frame FSM: STOP and START take priority over bit-level activity
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    b1_d        = b1_q;
    byte_done_d = byte_done_q;
    post_ack2_d = post_ack2_q;
    sda_oe_d    = sda_oe_q;
    reg_we_d    = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_data_d  = reg_data_q;
    busy_d      = busy_q;
    err_d       = 1'b0;

    if (stop_s) begin
      state_d     = IDLE;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
      byte_done_d = 1'b0;
      post_ack2_d = 1'b0;
      case (state_q)
        DEV, ACK_DEV, B1, ACK1: err_d = 1'b1;
        B2:                     err_d = ~post_ack2_q;
        default:                err_d = 1'b0;
      endcase
    end else if (start_s) begin
      state_d     = DEV;
      bit_cnt_d   = 3'd0;
      byte_done_d = 1'b0;
      post_ack2_d = 1'b0;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b1;
    end else begin
      case (state_q)
        DEV, B1, B2: begin
          if (scl_rise_s && !byte_done_q) begin
            shift_d     = {shift_q[6:0], sda_s};
            bit_cnt_d   = bit_cnt_q + 3'd1;
            byte_done_d = (bit_cnt_q == 3'd7);
          end else if (scl_fall_s && byte_done_q) begin
            byte_done_d = 1'b0;
            bit_cnt_d   = 3'd0;
            if (state_q == DEV) begin
              if (shift_q == {DEV_ADDR, 1'b0}) begin
                sda_oe_d = 1'b1;
                state_d  = ACK_DEV;
              end else begin
                err_d   = 1'b1;
                state_d = WAIT_STOP;
              end
            end else if (state_q == B1) begin
              b1_d     = shift_q;
              sda_oe_d = 1'b1;
              state_d  = ACK1;
            end else if (post_ack2_q) begin
              // Any byte beyond the data byte is refused
              err_d   = 1'b1;
              state_d = WAIT_STOP;
            end else begin
              sda_oe_d   = 1'b1;
              reg_we_d   = 1'b1;
              reg_addr_d = b1_q[7:1];
              reg_data_d = {b1_q[0], shift_q};
              state_d    = ACK2;
            end
          end else begin
            state_d = state_q;
          end
        end
        ACK_DEV, ACK1, ACK2: begin
          if (scl_fall_s) begin
            sda_oe_d    = 1'b0;
            post_ack2_d = post_ack2_q | (state_q == ACK2);
            state_d     = (state_q == ACK_DEV) ? B1 : B2;
          end else begin
            state_d = state_q;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Async reset also drops the SDA pull-down mid-slot
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
      b1_q        <= 8'd0;
      byte_done_q <= 1'b0;
      post_ack2_q <= 1'b0;
      sda_oe_q    <= 1'b0;
      reg_we_q    <= 1'b0;
      reg_addr_q  <= 7'd0;
      reg_data_q  <= 9'd0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      b1_q        <= b1_d;
      byte_done_q <= byte_done_d;
      post_ack2_q <= post_ack2_d;
      sda_oe_q    <= sda_oe_d;
      reg_we_q    <= reg_we_d;
      reg_addr_q  <= reg_addr_d;
      reg_data_q  <= reg_data_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign o_sda_oe   = sda_oe_q;
  assign o_reg_we   = reg_we_q;
  assign o_reg_addr = reg_addr_q;
  assign o_reg_data = reg_data_q;
  assign o_busy     = busy_q;
  assign o_err      = err_q;

`ifdef I2C_TARGET_SHADOW_EN
  logic [8:0] shadow_q [SHADOW_DEPTH];
  logic [8:0] shadow_d [SHADOW_DEPTH];

  // Writing the codec reset register wipes the whole shadow copy
  always_comb begin
    shadow_d = shadow_q;
    if (reg_we_q) begin
      if (reg_addr_q == I2C_REG_RESET) begin
        for (int i = 0; i < SHADOW_DEPTH; i++) begin
          shadow_d[i] = 9'd0;
        end
      end else if (is_shadow_addr(reg_addr_q)) begin
        shadow_d[reg_addr_q[3:0]] = reg_data_q;
      end else begin
        shadow_d = shadow_q;
      end
    end else begin
      shadow_d = shadow_q;
    end
  end

  // Shadow register storage
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < SHADOW_DEPTH; i++) begin
        shadow_q[i] <= 9'd0;
      end
    end else begin
      shadow_q <= shadow_d;
    end
  end

  assign o_rd_data = shadow_q[i_rd_addr];
`else
  logic unused_rd_addr_s;
  assign unused_rd_addr_s = ^i_rd_addr;
  assign o_rd_data        = 9'd0;
`endif

endmodule

// File: tb/tb_i2c_codec_target.sv
// Directed bench for i2c_codec_target: bit-banged I2C frames with
// hand-computed expectations; shadow checks follow I2C_TARGET_SHADOW_EN.
module tb_i2c_codec_target;
  import i2c_pkg::*;

  localparam int Q = 6;

  logic       clk;
  logic       rst_n;
  logic       scl_host;
  logic       sda_host;
  logic       sda_line;
  logic       sda_oe;
  logic       reg_we;
  logic [6:0] reg_addr;
  logic [8:0] reg_data;
  logic       busy;
  logic       err;
  logic [3:0] rd_addr;
  logic [8:0] rd_data;

  int n_checks = 0;
  int n_fail   = 0;
  int we_cnt   = 0;
  int we_no_oe = 0;
  int err_cnt  = 0;
  int oe_cnt   = 0;

  assign sda_line = sda_host & ~sda_oe;

  i2c_codec_target dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_scl      (scl_host),
    .i_sda      (sda_line),
    .o_sda_oe   (sda_oe),
    .o_reg_we   (reg_we),
    .o_reg_addr (reg_addr),
    .o_reg_data (reg_data),
    .o_busy     (busy),
    .o_err      (err),
    .i_rd_addr  (rd_addr),
    .o_rd_data  (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reg_we) begin
      we_cnt++;
      if (!sda_oe) we_no_oe++;
    end
    if (err) err_cnt++;
    if (sda_oe) oe_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic hold_q;
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start;
    sda_host = 1'b1; hold_q();
    scl_host = 1'b1; hold_q();
    sda_host = 1'b0; hold_q();
    scl_host = 1'b0; hold_q();
  endtask

  task automatic i2c_stop;
    sda_host = 1'b0; hold_q();
    scl_host = 1'b1; hold_q();
    sda_host = 1'b1; hold_q();
  endtask

  task automatic i2c_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_host = b[i]; hold_q();
      scl_host = 1'b1; hold_q(); hold_q();
      scl_host = 1'b0; hold_q();
    end
  endtask

  task automatic i2c_ack(output logic ack);
    sda_host = 1'b1; hold_q();
    scl_host = 1'b1; hold_q();
    ack = ~sda_line;
    hold_q();
    scl_host = 1'b0; hold_q();
  endtask

  task automatic i2c_byte(input logic [7:0] b, output logic ack);
    i2c_bits(b);
    i2c_ack(ack);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ack;
    int   we0, err0, oe0;

    rst_n = 1'b0; scl_host = 1'b1; sda_host = 1'b1; rd_addr = 4'd6;
    repeat (3) @(negedge clk);
    check_eq("rst_sda_oe", 32'(sda_oe), 32'd0);
    check_eq("rst_reg_we", 32'(reg_we), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_addr", 32'(reg_addr), 32'd0);
    check_eq("rst_data", 32'(reg_data), 32'd0);
    check_eq("rst_rd_data", 32'(rd_data), 32'd0);
    check_eq("rst_state", 32'(dut.state_q), 32'(IDLE));
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // repeated START after B1, then a complete write to reg 0x06
    we0 = we_cnt; err0 = err_cnt;
    i2c_start();
    i2c_byte(8'h34, ack); check_eq("rs_ack_dev0", 32'(ack), 32'd1);
    i2c_byte(8'h10, ack); check_eq("rs_ack_b1_0", 32'(ack), 32'd1);
    i2c_start();
    i2c_byte(8'h34, ack); check_eq("rs_ack_dev", 32'(ack), 32'd1);
    i2c_byte(8'h0C, ack); check_eq("rs_ack_b1", 32'(ack), 32'd1);
    i2c_byte(8'h9F, ack); check_eq("rs_ack_b2", 32'(ack), 32'd1);
    check_eq("rs_busy_mid", 32'(busy), 32'd1);
    i2c_stop();
    check_eq("rs_we_cnt", 32'(we_cnt - we0), 32'd1);
    check_eq("rs_addr", 32'(reg_addr), 32'h06);
    check_eq("rs_data", 32'(reg_data), 32'h09F);
    check_eq("rs_err", 32'(err_cnt - err0), 32'd0);
    check_eq("rs_busy_end", 32'(busy), 32'd0);
    check_eq("rs_we_with_oe", 32'(we_no_oe), 32'd0);
`ifdef I2C_TARGET_SHADOW_EN
    check_eq("rs_shadow6", 32'(rd_data), 32'h09F);
`else
    check_eq("rs_rd_tied", 32'(rd_data), 32'd0);
`endif

    // valid write to the codec reset register
    we0 = we_cnt; err0 = err_cnt;
    i2c_start();
    i2c_byte(8'h34, ack); check_eq("vw_ack_dev", 32'(ack), 32'd1);
    i2c_byte(8'h1E, ack); check_eq("vw_ack_b1", 32'(ack), 32'd1);
    i2c_byte(8'h00, ack); check_eq("vw_ack_b2", 32'(ack), 32'd1);
    i2c_stop();
    check_eq("vw_we_cnt", 32'(we_cnt - we0), 32'd1);
    check_eq("vw_addr", 32'(reg_addr), 32'h0F);
    check_eq("vw_data", 32'(reg_data), 32'h000);
    check_eq("vw_err", 32'(err_cnt - err0), 32'd0);
    check_eq("vw_shadow6", 32'(rd_data), 32'd0);

    // wrong device address
    we0 = we_cnt; err0 = err_cnt; oe0 = oe_cnt;
    i2c_start();
    i2c_byte(8'h36, ack); check_eq("wa_ack_dev", 32'(ack), 32'd0);
    i2c_byte(8'h1E, ack); check_eq("wa_ack_b1", 32'(ack), 32'd0);
    i2c_stop();
    check_eq("wa_oe_cnt", 32'(oe_cnt - oe0), 32'd0);
    check_eq("wa_we_cnt", 32'(we_cnt - we0), 32'd0);
    check_eq("wa_err", 32'(err_cnt - err0), 32'd1);
    check_eq("wa_busy", 32'(busy), 32'd0);
    check_eq("wa_addr_held", 32'(reg_addr), 32'h0F);

    // read request
    err0 = err_cnt;
    i2c_start();
    i2c_byte(8'h35, ack); check_eq("rd_ack", 32'(ack), 32'd0);
    check_eq("rd_err", 32'(err_cnt - err0), 32'd1);
    check_eq("rd_state_wait", 32'(dut.state_q), 32'(WAIT_STOP));
    i2c_stop();
    check_eq("rd_state_idle", 32'(dut.state_q), 32'(IDLE));

    // abort after B1
    we0 = we_cnt; err0 = err_cnt;
    i2c_start();
    i2c_byte(8'h34, ack); check_eq("ab_ack_dev", 32'(ack), 32'd1);
    i2c_byte(8'h08, ack); check_eq("ab_ack_b1", 32'(ack), 32'd1);
    check_eq("ab_busy_mid", 32'(busy), 32'd1);
    i2c_stop();
    check_eq("ab_we_cnt", 32'(we_cnt - we0), 32'd0);
    check_eq("ab_err", 32'(err_cnt - err0), 32'd1);
    check_eq("ab_busy", 32'(busy), 32'd0);

    // extra byte after ACK2 is refused; data bit 8 comes from B1[0]
    we0 = we_cnt; err0 = err_cnt;
    i2c_start();
    i2c_byte(8'h34, ack);
    i2c_byte(8'h13, ack); check_eq("ex_ack_b1", 32'(ack), 32'd1);
    i2c_byte(8'h34, ack); check_eq("ex_ack_b2", 32'(ack), 32'd1);
    i2c_byte(8'h55, ack); check_eq("ex_nack", 32'(ack), 32'd0);
    check_eq("ex_err", 32'(err_cnt - err0), 32'd1);
    i2c_stop();
    check_eq("ex_we_cnt", 32'(we_cnt - we0), 32'd1);
    check_eq("ex_addr", 32'(reg_addr), 32'h09);
    check_eq("ex_data", 32'(reg_data), 32'h134);
    check_eq("ex_err_stop", 32'(err_cnt - err0), 32'd1);

    // reset asserted inside the ACK2 slot
    we0 = we_cnt;
    i2c_start();
    i2c_byte(8'h34, ack);
    i2c_byte(8'h0C, ack);
    i2c_bits(8'h9F);
    check_eq("rk_oe_in_slot", 32'(sda_oe), 32'd1);
    check_eq("rk_we_cnt", 32'(we_cnt - we0), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rk_oe_async", 32'(sda_oe), 32'd0);
    check_eq("rk_state", 32'(dut.state_q), 32'(IDLE));
    check_eq("rk_busy", 32'(busy), 32'd0);
    check_eq("rk_addr", 32'(reg_addr), 32'd0);
    repeat (3) @(negedge clk);
    scl_host = 1'b1; sda_host = 1'b1;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
